memory_cycle: RTL

- MEM stage of the 5-stage RISC-V pipeline. It consumes the E->M pipeline outputs and performs the data-memory access, then registers the M->W pipeline outputs.
- Drives a request/ready data-memory port, so wait-state memories are supported. Raises StallM to freeze IF/ID/EX while an access is pending.
- Detects misaligned word accesses and memory timeouts.

---
 rtl/memory_cycle_pkg.sv | 20 ++
 rtl/memory_cycle_wb.sv | 44 ++++
 rtl/memory_cycle.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/memory_cycle_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, W-stage bubble value, default timeout.
package memory_cycle_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memStateT;

  // Control half of an M->W bundle; a bubble is an instruction with every field cleared.
  typedef struct packed {
    logic       regWrite;
    logic       resultSrc;
    logic [4:0] rd;
  } wbCtrlT;

  localparam wbCtrlT BUBBLE_CTRL = '{regWrite: 1'b0, resultSrc: 1'b0, rd: 5'd0};

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/memory_cycle_wb.sv
// M->W pipeline register with synchronous reset and bubble insertion.
module mem_wb_reg
  import memory_cycle_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              RegWriteM,
  input  logic              ResultSrcM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [4:0]        RDM,
  input  logic [DATA_W-1:0] PCPlus4M,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [4:0]        RDW,
  output logic [DATA_W-1:0] PCPlus4W
);

  wbCtrlT ctrlReg;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ctrlReg    <= BUBBLE_CTRL;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
    end else begin
      ctrlReg    <= '{regWrite: RegWriteM, resultSrc: ResultSrcM, rd: RDM};
      ALUResultW <= ALUResultM;
      ReadDataW  <= ReadDataM;
      PCPlus4W   <= PCPlus4M;
    end
  end

  assign RegWriteW  = ctrlReg.regWrite;
  assign ResultSrcW = ctrlReg.resultSrc;
  assign RDW        = ctrlReg.rd;

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: drives a request/ready data-memory port, stalls upstream while waiting,
// flags misaligned accesses and sticky timeouts, and registers results into WB.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              ResultSrcM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [4:0]        RDM,
  input  logic [DATA_W-1:0] PCPlus4M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              StallM,
  output logic              MisalignM,
  output logic              MemErrM,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [4:0]        RDW,
  output logic [DATA_W-1:0] PCPlus4W
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  memStateT stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;

  // The whole instruction is held so WAIT never depends on the (frozen) M inputs.
  logic              holdWe, holdRegWrite, holdResultSrc;
  logic [ADDR_W-1:0] holdAddr;
  logic [DATA_W-1:0] holdWdata, holdAlu, holdPc;
  logic [4:0]        holdRd;

  logic              memOp, latch, errSet, bubble;
  logic              wbRegWrite, wbResultSrc;
  logic [DATA_W-1:0] wbAlu, wbReadData, wbPc;
  logic [4:0]        wbRd;

  assign memOp = ResultSrcM | MemWriteM;

  always_comb begin
    stateNext   = stateReg;
    cntNext     = '0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = ADDR_W'(ALUResultM);
    dmem_wdata  = WriteDataM;
    StallM      = 1'b0;
    MisalignM   = 1'b0;
    latch       = 1'b0;
    errSet      = 1'b0;
    bubble      = 1'b0;
    wbRegWrite  = RegWriteM;
    wbResultSrc = ResultSrcM;
    wbAlu       = ALUResultM;
    wbRd        = RDM;
    wbPc        = PCPlus4M;
    wbReadData  = '0;
    unique case (stateReg)
      IDLE: begin
        if (memOp && (ALUResultM[1:0] != 2'b00)) begin
          MisalignM = 1'b1;
          bubble    = 1'b1;
        end else if (memOp) begin
          dmem_req = 1'b1;
          dmem_we  = MemWriteM;
          latch    = 1'b1;
          if (dmem_ready) begin
            wbReadData = ResultSrcM ? dmem_rdata : '0;
          end else begin
            StallM    = 1'b1;
            bubble    = 1'b1;
            stateNext = WAIT;
            cntNext   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        dmem_req    = 1'b1;
        dmem_we     = holdWe;
        dmem_addr   = holdAddr;
        dmem_wdata  = holdWdata;
        wbRegWrite  = holdRegWrite;
        wbResultSrc = holdResultSrc;
        wbAlu       = holdAlu;
        wbRd        = holdRd;
        wbPc        = holdPc;
        if (dmem_ready) begin
          wbReadData = holdResultSrc ? dmem_rdata : '0;
          stateNext  = IDLE;
        end else if (cntReg < CNT_LAST) begin
          StallM  = 1'b1;
          bubble  = 1'b1;
          cntNext = cntReg + CNT_W'(1);
        end else begin
          // Abort: retire the instruction without a register write so the pipeline moves on.
          errSet     = 1'b1;
          wbRegWrite = 1'b0;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg      <= IDLE;
      cntReg        <= '0;
      MemErrM       <= 1'b0;
      holdWe        <= 1'b0;
      holdRegWrite  <= 1'b0;
      holdResultSrc <= 1'b0;
      holdAddr      <= '0;
      holdWdata     <= '0;
      holdAlu       <= '0;
      holdPc        <= '0;
      holdRd        <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (errSet) MemErrM <= 1'b1;
      if (latch) begin
        holdWe        <= MemWriteM;
        holdRegWrite  <= RegWriteM;
        holdResultSrc <= ResultSrcM;
        holdAddr      <= ADDR_W'(ALUResultM);
        holdWdata     <= WriteDataM;
        holdAlu       <= ALUResultM;
        holdPc        <= PCPlus4M;
        holdRd        <= RDM;
      end
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W)) wbReg (
    .clk        (clk),
    .rst        (rst),
    .bubble     (bubble),
    .RegWriteM  (wbRegWrite),
    .ResultSrcM (wbResultSrc),
    .ALUResultM (wbAlu),
    .ReadDataM  (wbReadData),
    .RDM        (wbRd),
    .PCPlus4M   (wbPc),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .RDW        (RDW),
    .PCPlus4W   (PCPlus4W)
  );

endmodule
